// File: rtl/usb_ep0_ctrl.sv
// usb_ep0_ctrl: endpoint-0 control-transfer sequencer between the usb core and a descriptor ROM.
// Captures SETUP packets and decodes standard requests. Streams GET_DESCRIPTOR data stages
// from the ROM in MAX_PKT-sized packets and runs the status stage. Owns the device address
// and the configuration flag.
// Ports:
//   clk_48, rst_n, usb_rst        clock, async reset, synchronous bus reset
//   transaction_active, endpoint, direction_in, setup, data_strobe, data_out, success
//                                 per-transaction info and pulses from the core
//   rom_addr / rom_data           descriptor ROM port (data valid 1 cycle after address)
//   usb_address, configured       device state
//   handshake, data_toggle, data_in, data_in_valid
//                                 per-transaction response to the core
module usb_ep0_ctrl #(
  parameter int unsigned MAX_PKT  = 64,
  parameter int unsigned ROM_AW   = 8,
  parameter int unsigned DEV_ADDR = 0,
  parameter int unsigned DEV_LEN  = 18,
  parameter int unsigned CFG_ADDR = 18,
  parameter int unsigned CFG_LEN  = 9
) (
  input  logic              clk_48,
  input  logic              rst_n,
  input  logic              usb_rst,
  input  logic              transaction_active,
  input  logic [3:0]        endpoint,
  input  logic              direction_in,
  input  logic              setup,
  input  logic              data_strobe,
  input  logic [7:0]        data_out,
  input  logic              success,
  input  logic [7:0]        rom_data,
  output logic [6:0]        usb_address,
  output logic [1:0]        handshake,
  output logic              data_toggle,
  output logic [7:0]        data_in,
  output logic              data_in_valid,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              configured
);
  localparam int unsigned PW = 7;  // packet byte count, holds up to 64
  localparam logic [1:0] HS_ACK   = 2'b00;
  localparam logic [1:0] HS_NAK   = 2'b10;
  localparam logic [1:0] HS_STALL = 2'b11;

  typedef enum logic [2:0] {IDLE, SETUP_RX, DECODE, DATA_IN, STATUS_IN, STALL} state_t;

  state_t            state;
  logic              strobe_q, success_q, active_q;
  logic [3:0]        setup_cnt;
  logic [7:0]        req_type, request;
  logic [15:0]       w_value, w_length;
  logic [ROM_AW-1:0] src_base;
  logic [15:0]       req_len, remaining, ptr;
  logic [PW-1:0]     pkt_len, byte_idx;
  logic              toggle, zlp_needed;
  logic [6:0]        pending_addr;
  logic              addr_pending;
  logic              in_pkt, out_stat;
  logic [1:0]        fetch;  // ROM read in flight; capture into data_in when fetch[1]

  logic              strobe_p, success_p, ta_rise, ta_fall, ep0;
  logic [PW-1:0]     next_len;
  logic              desc_ok;
  logic [ROM_AW-1:0] d_base;
  logic [15:0]       d_len, min_len;

  // Pulse edges, packet sizing and descriptor selection
  always_comb begin
    strobe_p  = data_strobe & ~strobe_q;
    success_p = success & ~success_q;
    ta_rise   = transaction_active & ~active_q;
    ta_fall   = ~transaction_active & active_q;
    ep0       = (endpoint == 4'd0);
    next_len  = (remaining > 16'(MAX_PKT)) ? PW'(MAX_PKT) : PW'(remaining);
    desc_ok   = 1'b0;
    d_base    = '0;
    d_len     = '0;
    case (w_value[15:8])
      8'd1: begin desc_ok = 1'b1; d_base = ROM_AW'(DEV_ADDR); d_len = 16'(DEV_LEN); end
      8'd2: begin desc_ok = 1'b1; d_base = ROM_AW'(CFG_ADDR); d_len = 16'(CFG_LEN); end
      default: ;
    endcase
    min_len = (w_length < d_len) ? w_length : d_len;
  end

  // Sequencer: state, transfer bookkeeping and all registered outputs
  always_ff @(posedge clk_48 or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      strobe_q <= 1'b0; success_q <= 1'b0; active_q <= 1'b0;
      setup_cnt <= '0; req_type <= '0; request <= '0; w_value <= '0; w_length <= '0;
      src_base <= '0; req_len <= '0; remaining <= '0; ptr <= '0;
      pkt_len <= '0; byte_idx <= '0; toggle <= 1'b0; zlp_needed <= 1'b0;
      pending_addr <= '0; addr_pending <= 1'b0; in_pkt <= 1'b0; out_stat <= 1'b0; fetch <= '0;
      usb_address <= '0; handshake <= HS_ACK; data_toggle <= 1'b0;
      data_in <= '0; data_in_valid <= 1'b0; rom_addr <= '0; configured <= 1'b0;
    end else if (usb_rst) begin
      // Track live inputs so a transaction already in progress is not seen as a new one.
      state <= IDLE;
      strobe_q <= data_strobe; success_q <= success; active_q <= transaction_active;
      setup_cnt <= '0; toggle <= 1'b0; zlp_needed <= 1'b0;
      pending_addr <= '0; addr_pending <= 1'b0; in_pkt <= 1'b0; out_stat <= 1'b0; fetch <= '0;
      usb_address <= '0; handshake <= HS_ACK; data_toggle <= 1'b0;
      data_in <= '0; data_in_valid <= 1'b0; rom_addr <= '0; configured <= 1'b0;
    end else begin
      strobe_q  <= data_strobe;
      success_q <= success;
      active_q  <= transaction_active;
      fetch     <= {fetch[0], 1'b0};
      if (fetch[1]) begin
        data_in       <= rom_data;
        data_in_valid <= 1'b1;
      end

      if (ta_rise && !ep0) begin
        handshake     <= HS_NAK;
        data_in_valid <= 1'b0;
      end else if (ta_rise && setup) begin
        state         <= SETUP_RX;
        setup_cnt     <= '0;
        handshake     <= HS_ACK;
        addr_pending  <= 1'b0;
        in_pkt        <= 1'b0;
        out_stat      <= 1'b0;
        fetch         <= '0;
        data_in_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: if (ta_rise) handshake <= direction_in ? HS_NAK : HS_ACK;

          SETUP_RX: begin
            if (strobe_p && !direction_in && setup_cnt < 4'd8) begin
              case (setup_cnt[2:0])
                3'd0: req_type        <= data_out;
                3'd1: request         <= data_out;
                3'd2: w_value[7:0]    <= data_out;
                3'd3: w_value[15:8]   <= data_out;
                3'd6: w_length[7:0]   <= data_out;
                3'd7: w_length[15:8]  <= data_out;
                default: ;  // wIndex is not needed by any supported request
              endcase
              setup_cnt <= setup_cnt + 4'd1;
            end
            if (success_p)    state <= (setup_cnt == 4'd8) ? DECODE : IDLE;
            else if (ta_fall) state <= IDLE;
          end

          DECODE: begin
            state <= STALL;
            if (req_type == 8'h80 && request == 8'h06 && desc_ok) begin
              src_base   <= d_base;
              req_len    <= w_length;
              remaining  <= min_len;
              ptr        <= '0;
              toggle     <= 1'b1;
              zlp_needed <= (min_len == 16'd0);
              state      <= DATA_IN;
            end else if (req_type == 8'h00 && request == 8'h05) begin
              pending_addr <= w_value[6:0];
              addr_pending <= 1'b1;
              state        <= STATUS_IN;
            end else if (req_type == 8'h00 && request == 8'h09) begin
              configured <= (w_value[7:0] != 8'd0);
              state      <= STATUS_IN;
            end
          end

          DATA_IN: begin
            if (ta_rise) begin
              handshake     <= HS_ACK;
              data_in_valid <= 1'b0;
              byte_idx      <= '0;
              if (!direction_in) begin
                out_stat <= 1'b1;
              end else if (remaining != 16'd0 || zlp_needed) begin
                in_pkt      <= 1'b1;
                pkt_len     <= next_len;
                data_toggle <= toggle;
                rom_addr    <= src_base + ROM_AW'(ptr);
                fetch       <= {1'b0, remaining != 16'd0};
              end else begin
                handshake <= HS_NAK;
              end
            end
            if (in_pkt && strobe_p && byte_idx < pkt_len) begin
              byte_idx <= byte_idx + PW'(1);
              if (byte_idx + PW'(1) < pkt_len) begin
                rom_addr <= src_base + ROM_AW'(ptr + 16'(byte_idx) + 16'd1);
                fetch    <= 2'b01;
              end else begin
                data_in_valid <= 1'b0;
              end
            end
            if (in_pkt && success_p) begin
              ptr        <= ptr + 16'(pkt_len);
              remaining  <= remaining - 16'(pkt_len);
              toggle     <= ~toggle;
              // ZLP only after a full final packet that still fell short of wLength
              zlp_needed <= (pkt_len == PW'(MAX_PKT)) && (remaining == 16'(pkt_len)) &&
                            (ptr + 16'(pkt_len) < req_len);
            end
            if (out_stat && success_p) state <= IDLE;
            if (ta_fall || (in_pkt && success_p) || (out_stat && success_p)) begin
              in_pkt        <= 1'b0;
              out_stat      <= 1'b0;
              data_in_valid <= 1'b0;
              fetch         <= '0;
            end
          end

          STATUS_IN: begin
            if (ta_rise) begin
              if (direction_in) begin
                handshake     <= HS_ACK;
                data_toggle   <= 1'b1;
                data_in_valid <= 1'b0;
                in_pkt        <= 1'b1;
              end else begin
                handshake <= HS_NAK;
              end
            end
            if (in_pkt && success_p) begin
              if (addr_pending) usb_address <= pending_addr;
              addr_pending <= 1'b0;
              in_pkt       <= 1'b0;
              state        <= IDLE;
            end else if (ta_fall) begin
              in_pkt <= 1'b0;
            end
          end

          STALL: if (ta_rise) handshake <= HS_STALL;

          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/usb_ep0_ctrl.md
# usb_ep0_ctrl

Endpoint-0 control-transfer sequencer between the `usb` core and a descriptor ROM. It captures SETUP packets and decodes standard requests. It streams GET_DESCRIPTOR data stages from the ROM in MAX_PKT-sized packets, runs the status stage, and owns the device address and configuration state. It drives the core's per-transaction handshake, data toggle and IN data byte stream.

## Interface
- MAX_PKT, 64: ep0 max packet size in bytes (8/16/32/64).
- ROM_AW, 8: descriptor ROM address width.
- DEV_ADDR, 0: ROM offset of the device descriptor.
- DEV_LEN, 18: device descriptor length.
- CFG_ADDR, 18: ROM offset of the configuration descriptor.
- CFG_LEN, 9: total configuration descriptor length.

Ports:
- clk_48  in  1  48 MHz clock, single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- usb_rst  in  1  bus reset from the core; synchronous clear, same effect as rst_n.
- transaction_active  in  1  core transaction in progress.
- endpoint  in  4  endpoint of the current transaction.
- direction_in  in  1  1 = IN (device to host).
- setup  in  1  current transaction is SETUP.
- data_strobe  in  1  byte handshake pulse: OUT byte valid on data_out, or IN byte consumed.
- data_out  in  8  received byte.
- success  in  1  transaction completed, CRC good / host ACKed.
- rom_data  in  8  ROM read data, valid 1 cycle after rom_addr.
- usb_address  out  7  device address.
- handshake  out  2  00 ack, 01 none, 10 nak, 11 stall.
- data_toggle  out  1  DATA0/DATA1 select for IN packets.
- data_in  out  8  IN byte.
- data_in_valid  out  1  another IN byte is available; low ends the packet.
- rom_addr  out  ROM_AW  ROM read address.
- configured  out  1  nonzero SET_CONFIGURATION received.

## Operation
- The core's data_strobe and success signals are treated as pulses. Each is edge-detected internally, so one event is counted once.
- States: IDLE, SETUP_RX, DECODE, DATA_IN, STATUS_IN, STALL.
- Any SETUP on ep0, in any state, enters SETUP_RX. Entry clears the setup byte count and sets handshake = ack.
- SETUP_RX stores bytes 0..7 in order. Bytes beyond 8 are ignored.
  - success with count = 8: go to DECODE.
  - success with count ≠ 8, or transaction end without success: go to IDLE.
- DECODE takes one cycle.
  - (0x80, 0x06) with wValue[15:8] = 1: source is DEV. With wValue[15:8] = 2: source is CFG.
    - remaining = min(wLength, source length).
    - Set the packet pointer, set toggle = 1, then go to DATA_IN.
  - Any other descriptor type: STALL.
  - (0x00, 0x05): pending_addr = wValue[6:0]; go to STATUS_IN.
  - (0x00, 0x09): configured = (wValue[7:0] ≠ 0); go to STATUS_IN.
  - All other requests: STALL.
- DATA_IN, IN transaction on ep0:
  - Send min(remaining, MAX_PKT) bytes from the packet pointer.
  - data_in_valid is deasserted once the packet's byte count is reached.
  - On success: advance the pointer, subtract the sent count from remaining, and flip the toggle.
  - Without success (host retry): pointer, remaining and toggle are unchanged, and the same packet is re-sent.
  - After the last packet, a zero-length packet (ZLP) is sent only when the last packet was full and the total sent is less than wLength.
- DATA_IN, OUT transaction on ep0: this is the status stage. handshake = ack; on success go to IDLE.
- STATUS_IN: the next IN on ep0 sends a ZLP with toggle = 1.
  - On success: usb_address <= pending_addr (only if SET_ADDRESS is pending), then go to IDLE.
  - Without success: repeat the ZLP.
- STALL: handshake = stall for every non-SETUP transaction on ep0, until the next SETUP.
- Endpoints other than 0: handshake = nak, data_in_valid = 0, with no state change.
- IDLE: IN on ep0 is answered with nak. OUT on ep0 is answered with ack and the data is discarded.
- Widths:
  - remaining and the pointer are 16 bits internally.
  - rom_addr = source base + pointer, truncated to ROM_AW.
  - wLength = 0 makes remaining 0, so DATA_IN sends only a ZLP and no ROM reads occur.

## Timing
- Reset values (rst_n low or usb_rst):
  - state IDLE
  - usb_address 0, handshake 00, data_toggle 0
  - data_in 0x00, data_in_valid 0
  - rom_addr 0, configured 0
  - pending address cleared
- rst_n asserted mid-transfer: outputs go to their reset values immediately (asynchronous).
- usb_rst asserted mid-transfer: the same values are applied on the next clock edge.
- IN packet start:
  - data_in and data_in_valid are valid no later than 3 cycles after the rising edge of transaction_active.
  - data_toggle is stable from that rising edge until transaction end.
- Byte advance: after each data_strobe, the next byte is on data_in within 2 cycles, including the 1-cycle ROM latency. A byte time is 32 cycles.
- handshake is valid within 1 cycle after transaction_active rises and holds until it falls.
- The usb_address update happens exactly 1 cycle after the success pulse of the status IN, never earlier.
- Simultaneous SETUP arrival and usb_rst: usb_rst wins.

## Test plan
- GET_DESCRIPTOR device, SETUP 80 06 00 01 00 00 40 00 with MAX_PKT = 64:
  - IN sends 18 bytes from ROM[0..17] with DATA1, then data_in_valid drops.
  - An OUT ZLP is acked and the state returns to IDLE.
- Same request with wLength = 8: IN sends 8 bytes, and no ZLP follows.
- MAX_PKT = 8, CFG_LEN = 16, wLength = 0xFF:
  - Packets are 8 bytes (DATA1) then 8 bytes (DATA0), then a ZLP with DATA1.
  - A repeated IN without success re-sends the identical packet and toggle.
- SET_ADDRESS 00 05 2A 00 00 00 00 00:
  - usb_address stays 0 through the status IN ZLP.
  - usb_address becomes 0x2A 1 cycle after that IN's success.
- Unsupported request 80 06 00 03 ...: the following IN and OUT on ep0 are stalled. A new valid SETUP clears the stall.
- usb_rst pulse during DATA_IN of a config fetch, after address 5 was set:
  - usb_address is 0, data_in_valid is 0 and the state is IDLE.
  - An IN on ep 1 gets nak.
